// File: rtl/ads127l1x_tdm_frame_deserializer_if.sv
// Delivery bus carrying one complete set of channel packets from the TDM deserializer.
interface ads127l1x_tdm_frame_deserializer_if #(
    parameter int unsigned CHANNEL_COUNT   = 8,
    parameter int unsigned BITS_PER_PACKET = 24
);
    localparam int unsigned PKT_W = CHANNEL_COUNT * BITS_PER_PACKET;

    logic [PKT_W-1:0] packets_out;
    logic             packets_valid;

    modport master (output packets_out, output packets_valid);
    modport slave  (input  packets_out, input  packets_valid);
endinterface

// File: rtl/ads127l1x_tdm_frame_deserializer.sv
// ADS127L14/L18 TDM DATA-port deserializer: FSYNC-framed lane shifters, frame-integrity
// checks and frame-length measurement, delivering all channels on one flat strobed bus.
module ads127l1x_tdm_frame_deserializer #(
    parameter int unsigned CHANNEL_COUNT   = 8,
    parameter int unsigned LANE_COUNT      = 8,
    parameter int unsigned BITS_PER_PACKET = 24,
    parameter int unsigned FRAME_CNT_W     = 16,
    parameter int unsigned FLEN_W          = 12
) (
    input  logic                   ADC_DCLK,
    input  logic                   RESET,
    input  logic                   ADC_FSYNC,
    input  logic [LANE_COUNT-1:0]  ADC_DOUT,
    input  logic                   err_clr,
    ads127l1x_tdm_frame_deserializer_if.master pkt,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic [FLEN_W-1:0]      frame_dclks,
    output logic                   locked,
    output logic                   short_frame_err,
    output logic                   len_change_err
);
    localparam int unsigned CPL       = CHANNEL_COUNT / LANE_COUNT;
    localparam int unsigned DATA_BITS = CPL * BITS_PER_PACKET;
    localparam int unsigned PKT_W     = CHANNEL_COUNT * BITS_PER_PACKET;
    localparam int unsigned CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    generate
        if (!((CHANNEL_COUNT == 4) || (CHANNEL_COUNT == 8)) ||
            !((LANE_COUNT == 1) || (LANE_COUNT == 2) || (LANE_COUNT == 4) || (LANE_COUNT == 8)) ||
            (LANE_COUNT > CHANNEL_COUNT) || ((CHANNEL_COUNT % LANE_COUNT) != 0) ||
            !((BITS_PER_PACKET == 16) || (BITS_PER_PACKET == 24) ||
              (BITS_PER_PACKET == 32) || (BITS_PER_PACKET == 40))) begin : g_bad_cfg
            $error("ads127l1x_tdm_frame_deserializer: illegal channel/lane/packet configuration");
        end
    endgenerate

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH, ST_WAIT} state_t;

    state_t                 state_q;
    logic                   fsync_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [FLEN_W-1:0]      len_q;
    logic [1:0]             rise_cnt_q;
    logic [PKT_W-1:0]       packets_q;
    logic                   valid_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [FLEN_W-1:0]      frame_dclks_q;
    logic                   locked_q;
    logic                   short_err_q;
    logic                   len_err_q;
    logic [DATA_BITS-1:0]   sh_q [LANE_COUNT];
    logic [PKT_W-1:0]       decoded;
    logic                   rise;
    logic                   short_set;
    logic                   len_set;

    assign rise      = ADC_FSYNC & ~fsync_q;
    assign short_set = rise && (state_q == ST_SHIFT);
    assign len_set   = rise && locked_q && (rise_cnt_q == 2'd2) && (len_q != frame_dclks_q);

    // Lane l holds channels l*CPL.. in arrival order, so the earliest channel sits at the top.
    for (genvar l = 0; l < LANE_COUNT; l++) begin : g_lane
        always_ff @(posedge ADC_DCLK) begin
            if (RESET) begin
                sh_q[l] <= '0;
            end else begin
                sh_q[l] <= {sh_q[l][DATA_BITS-2:0], ADC_DOUT[l]};
            end
        end
        for (genvar k = 0; k < CPL; k++) begin : g_ch
            assign decoded[(l*CPL+k)*BITS_PER_PACKET +: BITS_PER_PACKET] =
                sh_q[l][(CPL-1-k)*BITS_PER_PACKET +: BITS_PER_PACKET];
        end
    end

    always_ff @(posedge ADC_DCLK) begin
        if (RESET) begin
            state_q       <= ST_IDLE;
            fsync_q       <= 1'b1;
            bit_cnt_q     <= '0;
            len_q         <= '0;
            rise_cnt_q    <= '0;
            packets_q     <= '0;
            valid_q       <= 1'b0;
            frame_cnt_q   <= '0;
            frame_dclks_q <= '0;
            locked_q      <= 1'b0;
            short_err_q   <= 1'b0;
            len_err_q     <= 1'b0;
        end else begin
            fsync_q <= ADC_FSYNC;
            valid_q <= 1'b0;

            // Frame length counts the rise cycle as 1 and saturates.
            if (rise) begin
                len_q <= FLEN_W'(1);
            end else if (len_q != '1) begin
                len_q <= len_q + FLEN_W'(1);
            end
            if (rise) begin
                if (rise_cnt_q != 2'd0) begin
                    frame_dclks_q <= len_q;
                end
                if (rise_cnt_q != 2'd2) begin
                    rise_cnt_q <= rise_cnt_q + 2'd1;
                end
            end

            short_err_q <= short_set | (short_err_q & ~err_clr);
            len_err_q   <= len_set | (len_err_q & ~err_clr);

            // bit_cnt_q holds the number of bits already captured in the current frame.
            case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (rise) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= CNT_W'(1);
                    end
                end
                ST_SHIFT: begin
                    if (rise) begin
                        bit_cnt_q <= CNT_W'(1);
                    end else if (bit_cnt_q == LAST_BIT) begin
                        state_q <= ST_LATCH;
                    end else begin
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                    end
                end
                ST_LATCH: begin
                    packets_q   <= decoded;
                    valid_q     <= 1'b1;
                    frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
                    locked_q    <= 1'b1;
                    if (rise) begin
                        state_q   <= ST_SHIFT;
                        bit_cnt_q <= CNT_W'(1);
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pkt.packets_out   = packets_q;
    assign pkt.packets_valid = valid_q;
    assign frame_count       = frame_cnt_q;
    assign frame_dclks       = frame_dclks_q;
    assign locked            = locked_q;
    assign short_frame_err   = short_err_q;
    assign len_change_err    = len_err_q;
endmodule

// File: tb/tb_ads127l1x_tdm_frame_deserializer.sv
// Scoreboarded bench: an 8-lane/24-bit instance and a 2-lane/4-channel/32-bit instance.
module tb_ads127l1x_tdm_frame_deserializer;
    typedef struct {
        logic [319:0] pk;
        int           fc;
        int           cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int fc_a = 0;
    int fc_b = 0;
    int strobes_a = 0;
    int strobes_b = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea;
    exp_t eb;

    logic        rst_a = 1'b1, fsync_a = 1'b0, err_clr_a = 1'b0;
    logic [7:0]  dout_a = '0;
    logic [15:0] frame_count_a;
    logic [11:0] frame_dclks_a;
    logic        locked_a, short_a, lenerr_a;

    logic        rst_b = 1'b1, fsync_b = 1'b0, err_clr_b = 1'b0;
    logic [1:0]  dout_b = '0;
    logic [3:0]  frame_count_b;
    logic [11:0] frame_dclks_b;
    logic        locked_b, short_b, lenerr_b;

    ads127l1x_tdm_frame_deserializer_if #(.CHANNEL_COUNT(8), .BITS_PER_PACKET(24)) pkt_a ();
    ads127l1x_tdm_frame_deserializer_if #(.CHANNEL_COUNT(4), .BITS_PER_PACKET(32)) pkt_b ();

    ads127l1x_tdm_frame_deserializer #(
        .CHANNEL_COUNT(8), .LANE_COUNT(8), .BITS_PER_PACKET(24), .FRAME_CNT_W(16), .FLEN_W(12)
    ) dut_a (
        .ADC_DCLK(clk), .RESET(rst_a), .ADC_FSYNC(fsync_a), .ADC_DOUT(dout_a),
        .err_clr(err_clr_a), .pkt(pkt_a), .frame_count(frame_count_a),
        .frame_dclks(frame_dclks_a), .locked(locked_a),
        .short_frame_err(short_a), .len_change_err(lenerr_a)
    );

    ads127l1x_tdm_frame_deserializer #(
        .CHANNEL_COUNT(4), .LANE_COUNT(2), .BITS_PER_PACKET(32), .FRAME_CNT_W(4), .FLEN_W(12)
    ) dut_b (
        .ADC_DCLK(clk), .RESET(rst_b), .ADC_FSYNC(fsync_b), .ADC_DOUT(dout_b),
        .err_clr(err_clr_b), .pkt(pkt_b), .frame_count(frame_count_b),
        .frame_dclks(frame_dclks_b), .locked(locked_b),
        .short_frame_err(short_b), .len_change_err(lenerr_b)
    );

    task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Drives one frame of `period` DCLKs on instance A (sel_b=0) or B (sel_b=1).
    task automatic drive_frame(input bit sel_b, input logic [319:0] chd, input int period,
                               input int clr_at, input bit push);
        int   cpl, bpp, lanes, dbits;
        logic [7:0] lv;
        exp_t e;
        lanes = sel_b ? 2 : 8;
        bpp   = sel_b ? 32 : 24;
        cpl   = sel_b ? 2 : 1;
        dbits = cpl * bpp;
        for (int k = 0; k < period; k++) begin
            @(negedge clk);
            if (k == 0 && push) begin
                e.pk  = chd;
                e.cyc = cyc + 1 + dbits;
                if (sel_b) begin
                    fc_b++;
                    e.fc = fc_b % 16;
                    q_b.push_back(e);
                end else begin
                    fc_a++;
                    e.fc = fc_a % 65536;
                    q_a.push_back(e);
                end
            end
            lv = '0;
            if (k < dbits) begin
                for (int l = 0; l < lanes; l++) begin
                    lv[l] = chd[(l * cpl + k / bpp) * bpp + (bpp - 1 - k % bpp)];
                end
            end
            if (sel_b) begin
                fsync_b = (k == 0);
                dout_b = lv[1:0];
                err_clr_b = (k == clr_at);
            end else begin
                fsync_a = (k == 0);
                dout_a = lv;
                err_clr_a = (k == clr_at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (pkt_a.packets_valid === 1'b1) begin
            strobes_a++;
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL strobe_a unexpected strobe at cycle %0d", cyc);
            end else begin
                ea = q_a.pop_front();
                chk("pkt_a", 320'(pkt_a.packets_out), ea.pk);
                chk("fcnt_a", 320'(frame_count_a), 320'(ea.fc));
                chk("lat_a", 320'(cyc), 320'(ea.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (pkt_b.packets_valid === 1'b1) begin
            strobes_b++;
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL strobe_b unexpected strobe at cycle %0d", cyc);
            end else begin
                eb = q_b.pop_front();
                chk("pkt_b", 320'(pkt_b.packets_out), eb.pk);
                chk("fcnt_b", 320'(frame_count_b), 320'(eb.fc));
                chk("lat_b", 320'(cyc), 320'(eb.cyc));
            end
        end
    end

    initial begin
        logic [319:0] chd;
        int s0;

        // Reset state of A
        repeat (3) @(negedge clk);
        chk("rst_pkt_a", 320'(pkt_a.packets_out), 320'(0));
        chk("rst_fcnt_a", 320'(frame_count_a), 320'(0));
        chk("rst_locked_a", 320'(locked_a), 320'(0));
        chk("rst_flen_a", 320'(frame_dclks_a), 320'(0));
        rst_a = 1'b0;
        @(negedge clk);

        // Single 24-bit frame, ch n = A50000+n
        chd = '0;
        for (int n = 0; n < 8; n++) chd[n*24 +: 24] = 24'hA50000 + 24'(n);
        drive_frame(1'b0, chd, 30, -1, 1'b1);
        chk("one_strobe_a", 320'(strobes_a), 320'(1));
        chk("locked_a", 320'(locked_a), 320'(1));
        chk("no_short_a", 320'(short_a), 320'(0));

        // Early FSYNC at bit 10, then a good frame
        chd = '0;
        for (int n = 0; n < 8; n++) chd[n*24 +: 24] = 24'h5A5A00 ^ 24'(n * 24'h111);
        drive_frame(1'b0, chd, 10, -1, 1'b0);
        chd = '0;
        for (int n = 0; n < 8; n++) chd[n*24 +: 24] = 24'h123400 + 24'(n * 24'h010101);
        drive_frame(1'b0, chd, 30, -1, 1'b1);
        chk("short_set_a", 320'(short_a), 320'(1));
        chk("strobes_after_short_a", 320'(strobes_a), 320'(2));
        @(negedge clk); err_clr_a = 1'b1;
        @(negedge clk); err_clr_a = 1'b0;
        chk("short_clr_a", 320'(short_a), 320'(0));
        chk("lenerr_clr_a", 320'(lenerr_a), 320'(0));

        // Period 256, 256, 255 while locked
        chd = '0;
        for (int n = 0; n < 8; n++) chd[n*24 +: 24] = 24'hFEDC00 - 24'(n);
        drive_frame(1'b0, chd, 256, -1, 1'b1);
        drive_frame(1'b0, chd, 256, -1, 1'b1);
        drive_frame(1'b0, chd, 255, 5, 1'b1);
        chk("lenerr_stable_a", 320'(lenerr_a), 320'(0));
        chk("flen256_a", 320'(frame_dclks_a), 320'(256));
        drive_frame(1'b0, chd, 30, -1, 1'b1);
        chk("lenerr_set_a", 320'(lenerr_a), 320'(1));
        chk("flen255_a", 320'(frame_dclks_a), 320'(255));
        @(negedge clk); err_clr_a = 1'b1;
        @(negedge clk); err_clr_a = 1'b0;
        chk("lenerr_clr2_a", 320'(lenerr_a), 320'(0));

        // Reset mid-frame with FSYNC held high through release
        @(negedge clk); fsync_a = 1'b1; dout_a = 8'hFF;
        repeat (8) @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        fc_a = 0;
        s0 = strobes_a;
        repeat (40) @(negedge clk);
        chk("rst_no_strobe_a", 320'(strobes_a), 320'(s0));
        chk("rst2_pkt_a", 320'(pkt_a.packets_out), 320'(0));
        chk("rst2_fcnt_a", 320'(frame_count_a), 320'(0));
        chk("rst2_locked_a", 320'(locked_a), 320'(0));
        chk("rst2_flen_a", 320'(frame_dclks_a), 320'(0));
        chk("rst2_lenerr_a", 320'(lenerr_a), 320'(0));
        fsync_a = 1'b0; dout_a = '0;
        chd = '0;
        for (int n = 0; n < 8; n++) chd[n*24 +: 24] = 24'h0F0F00 | 24'(n);
        drive_frame(1'b0, chd, 30, -1, 1'b1);
        chk("post_rst_strobe_a", 320'(strobes_a), 320'(s0 + 1));

        // Instance B: 2 lanes, 4 channels, 32 bits, back-to-back 64-DCLK frames
        chk("rst_fcnt_b", 320'(frame_count_b), 320'(0));
        chk("rst_valid_b", 320'(pkt_b.packets_valid), 320'(0));
        rst_b = 1'b0;
        @(negedge clk);
        for (int i = 1; i <= 17; i++) begin
            chd = '0;
            for (int n = 0; n < 4; n++) chd[n*32 +: 32] = {8'hC0, 8'(i), 8'hDE, 8'(n)};
            drive_frame(1'b1, chd, 64, -1, 1'b1);
            if (i == 5) begin
                chk("flen64_b", 320'(frame_dclks_b), 320'(64));
                chk("short_b", 320'(short_b), 320'(0));
                chk("lenerr_b", 320'(lenerr_b), 320'(0));
                chk("locked_b", 320'(locked_b), 320'(1));
            end
        end
        repeat (4) @(negedge clk);
        chk("wrap_fcnt_b", 320'(frame_count_b), 320'(1));
        chk("strobes_b", 320'(strobes_b), 320'(17));

        repeat (5) @(negedge clk);
        chk("drain_a", 320'(q_a.size()), 320'(0));
        chk("drain_b", 320'(q_b.size()), 320'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
